// File: rtl/axo_prefetch_pkg.sv
// axo_prefetch_pkg: shared types and helpers for the Axolotl32 instruction
// prefetch buffer.
//   pf_state_e : bus-side FSM encoding (AXO_PF_IDLE / AXO_PF_FETCH)
//   next_word  : sequential word address, wrapping modulo 2^32
package axo_prefetch_pkg;

  localparam int                ADDR_W     = 32;
  localparam logic [ADDR_W-1:0] WORD_BYTES = 32'd4;

  typedef enum logic {
    AXO_PF_IDLE  = 1'b0,
    AXO_PF_FETCH = 1'b1
  } pf_state_e;

  function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] addr);
    return addr + WORD_BYTES;
  endfunction

endpackage

// File: rtl/axo_sync_fifo.sv
// axo_sync_fifo: small synchronous FIFO with flush.
//   clk, rst            : clock, synchronous active-high reset (control only)
//   push, push_data     : write push_data at the tail
//   pop                 : drop the head entry (ignored when empty)
//   flush               : empty the FIFO; wins over push
//   head                : head entry, zero when empty
//   count               : number of valid entries (0..DEPTH)
module axo_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = push && ((count_q != DEPTH_C) || pop_ok);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/axo_prefetch.sv
// axo_prefetch: instruction prefetch buffer between the core program port and
// program memory. Sequential words are fetched ahead into a FIFO; a request for
// any address other than the FIFO head flushes it and redirects fetching.
//   clk, rst               : clock, synchronous active-high reset
//   prog_re, prog_addr     : core instruction request
//   prog_ready, prog_data  : same-cycle hit response (combinational from regs
//                            and prog_* inputs only, never from bus_*)
//   bus_re, bus_addr       : single outstanding read request to memory
//   bus_ready, bus_data    : memory completion and read data
module axo_prefetch
  import axo_prefetch_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_re,
  input  logic [31:0] prog_addr,
  output logic        prog_ready,
  output logic [31:0] prog_data,
  output logic        bus_re,
  output logic [31:0] bus_addr,
  input  logic        bus_ready,
  input  logic [31:0] bus_data
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  pf_state_e   state_q, state_d;
  logic [31:0] head_addr_q, head_addr_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        discard_q, discard_d;

  logic [CW-1:0] count, count_next;
  logic [31:0]   head_data;
  logic          hit, redirect, fetching, done, push, issue;
  logic [31:0]   target_addr;

  axo_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus_data),
    .pop       (hit),
    .flush     (redirect),
    .head      (head_data),
    .count     (count)
  );

  always_comb begin
    hit         = prog_re && (count != '0) && (prog_addr == head_addr_q);
    redirect    = prog_re && (prog_addr != head_addr_q);
    fetching    = (state_q == AXO_PF_FETCH);
    done        = fetching && bus_ready;
    // A completion is dropped if it belongs to a pre-redirect stream.
    push        = done && !discard_q && !redirect;
    target_addr = redirect ? prog_addr : fetch_addr_q;

    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else begin
      case ({push, hit})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end

    // Only one word can be in flight, so a request needs one free slot.
    issue = (!fetching || bus_ready) && (count_next < DEPTH_C);

    head_addr_d = head_addr_q;
    if (redirect)  head_addr_d = prog_addr;
    else if (hit)  head_addr_d = next_word(head_addr_q);

    // An in-flight request is never aborted; it is only marked stale.
    discard_d = discard_q;
    if (redirect && fetching && !bus_ready) discard_d = 1'b1;
    else if (done)                          discard_d = 1'b0;

    state_d      = state_q;
    req_addr_d   = req_addr_q;
    fetch_addr_d = target_addr;
    if (issue) begin
      state_d      = AXO_PF_FETCH;
      req_addr_d   = target_addr;
      fetch_addr_d = next_word(target_addr);
    end else if (!fetching || bus_ready) begin
      state_d = AXO_PF_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= AXO_PF_IDLE;
      head_addr_q  <= RESET_ADDR;
      fetch_addr_q <= RESET_ADDR;
      req_addr_q   <= '0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      discard_q    <= discard_d;
    end
  end

  // Outputs are forced quiet while reset is held, even before state clears.
  assign prog_ready = !rst && hit;
  assign prog_data  = rst ? '0 : head_data;
  assign bus_re     = !rst && fetching;
  assign bus_addr   = rst ? '0 : req_addr_q;

endmodule
